// File: rtl/pw_usb_pkg.sv
// Shared USB definitions for the front-end sniff path.
//   - PID nibble constants (PID[3:0] as seen on the wire)
//   - state encoding of the PID filter state machine
//   - pid_valid(): check of the PID byte against its own complement
package pw_usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_DATA2 = 4'h7;
  localparam logic [3:0] PID_MDATA = 4'hF;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_NYET  = 4'h6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PID  = 3'd1,
    ST_FWD  = 3'd2,
    ST_DROP = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // A PID byte carries its type nibble in [3:0] and the one's complement in [7:4].
  function automatic logic pid_valid(input logic [7:0] pid);
    return pid[7:4] == ~pid[3:0];
  endfunction

endpackage

// File: rtl/pw_pid_filter.sv
// Packet framing and PID filter for the UTMI sniff path.
// Frames UTMI receive traffic into packets, checks and classifies the PID
// byte, drops packets whose PID is set in I_drop_mask and forwards the rest
// as a registered byte stream (1 cycle latency) with SOP/EOP markers.
// Ports:
//   fe_clk, reset_i            clock, asynchronous active-high reset
//   I_enable                   allow new packets to start
//   I_clear_counts             1-cycle pulse, zeroes all counters
//   I_drop_mask[15:0]          bit n drops packets with PID[3:0] == n
//   I_data/I_rxvalid/I_rxactive/I_rxerror   UTMI receive side
//   O_data/O_data_valid/O_sop/O_eop/O_eop_err  forwarded stream
//   O_pid, O_pkt_len           PID and length of last forwarded packet
//   O_pkt_count/O_drop_count/O_err_count     wrapping statistics
module pw_pid_filter
  import pw_usb_pkg::*;
#(
  parameter int pLEN_WIDTH = 11,
  parameter int pCNT_WIDTH = 16
) (
  input  logic                  fe_clk,
  input  logic                  reset_i,
  input  logic                  I_enable,
  input  logic                  I_clear_counts,
  input  logic [15:0]           I_drop_mask,
  input  logic [7:0]            I_data,
  input  logic                  I_rxvalid,
  input  logic                  I_rxactive,
  input  logic                  I_rxerror,
  output logic [7:0]            O_data,
  output logic                  O_data_valid,
  output logic                  O_sop,
  output logic                  O_eop,
  output logic                  O_eop_err,
  output logic [3:0]            O_pid,
  output logic [pLEN_WIDTH-1:0] O_pkt_len,
  output logic [pCNT_WIDTH-1:0] O_pkt_count,
  output logic [pCNT_WIDTH-1:0] O_drop_count,
  output logic [pCNT_WIDTH-1:0] O_err_count
);

  localparam logic [pLEN_WIDTH-1:0] LEN_ONE = {{(pLEN_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [pLEN_WIDTH-1:0] len_sat_inc(input logic [pLEN_WIDTH-1:0] v);
    return (v == {pLEN_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_t                state_q, state_d;
  logic                  rxactive_p0;
  logic                  start;
  logic [pLEN_WIDTH-1:0] len_q, len_d, pkt_len_d;
  logic [7:0]            data_d;
  logic [3:0]            pid_d;
  logic                  dv_d, sop_d, eop_d, eop_err_d;
  logic                  inc_pkt, inc_drop, inc_err;

  // Rising edge of rxactive; only acted on from IDLE.
  assign start = I_enable && I_rxactive && !rxactive_p0;

  always_comb begin
    state_d   = state_q;
    data_d    = O_data;
    dv_d      = 1'b0;
    sop_d     = 1'b0;
    eop_d     = 1'b0;
    eop_err_d = 1'b0;
    pid_d     = O_pid;
    len_d     = len_q;
    pkt_len_d = O_pkt_len;
    inc_pkt   = 1'b0;
    inc_drop  = 1'b0;
    inc_err   = 1'b0;
    case (state_q)
      ST_IDLE, ST_PID: begin
        if (state_q == ST_PID && !I_rxactive) begin
          state_d = ST_IDLE;
        end else if (state_q == ST_PID || start) begin
          // The rising-edge cycle itself is already a PID cycle, so a PID
          // byte arriving together with rxactive is not lost.
          state_d = ST_PID;
          if (I_rxerror) begin
            state_d = ST_ERR;
            inc_err = 1'b1;
          end else if (I_rxvalid) begin
            if (!pid_valid(I_data)) begin
              state_d = ST_ERR;
              inc_err = 1'b1;
            end else if (I_drop_mask[I_data[3:0]]) begin
              state_d  = ST_DROP;
              inc_drop = 1'b1;
            end else begin
              state_d = ST_FWD;
              dv_d    = 1'b1;
              sop_d   = 1'b1;
              data_d  = I_data;
              pid_d   = I_data[3:0];
              len_d   = LEN_ONE;
            end
          end
        end
      end
      ST_FWD: begin
        if (!I_rxactive) begin
          state_d   = ST_IDLE;
          eop_d     = 1'b1;
          pkt_len_d = len_q;
          inc_pkt   = 1'b1;
        end else if (I_rxerror) begin
          // Byte on the error cycle is discarded; packet closes as errored.
          state_d   = ST_ERR;
          eop_d     = 1'b1;
          eop_err_d = 1'b1;
          inc_err   = 1'b1;
        end else if (I_rxvalid) begin
          dv_d   = 1'b1;
          data_d = I_data;
          len_d  = len_sat_inc(len_q);
        end
      end
      ST_DROP, ST_ERR: begin
        if (!I_rxactive) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p0: state register and registered stream outputs
  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      rxactive_p0  <= 1'b0;
      len_q        <= '0;
      O_data       <= '0;
      O_data_valid <= 1'b0;
      O_sop        <= 1'b0;
      O_eop        <= 1'b0;
      O_eop_err    <= 1'b0;
      O_pid        <= '0;
      O_pkt_len    <= '0;
    end else begin
      state_q      <= state_d;
      rxactive_p0  <= I_rxactive;
      len_q        <= len_d;
      O_data       <= data_d;
      O_data_valid <= dv_d;
      O_sop        <= sop_d;
      O_eop        <= eop_d;
      O_eop_err    <= eop_err_d;
      O_pid        <= pid_d;
      O_pkt_len    <= pkt_len_d;
    end
  end

  // Statistics counters; a clear wins over a same-cycle increment.
  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      O_pkt_count  <= '0;
      O_drop_count <= '0;
      O_err_count  <= '0;
    end else if (I_clear_counts) begin
      O_pkt_count  <= '0;
      O_drop_count <= '0;
      O_err_count  <= '0;
    end else begin
      if (inc_pkt)  O_pkt_count  <= O_pkt_count + 1'b1;
      if (inc_drop) O_drop_count <= O_drop_count + 1'b1;
      if (inc_err)  O_err_count  <= O_err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pw_pid_filter.sv
// Self-checking bench for pw_pid_filter: directed scenarios plus a randomized
// packet stream checked against a packet-level reference model.
module tb_pw_pid_filter;

  typedef logic [7:0] bq_t[$];

  logic        fe_clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        I_enable = 1'b1;
  logic        I_clear_counts = 1'b0;
  logic [15:0] I_drop_mask = '0;
  logic [7:0]  I_data = '0;
  logic        I_rxvalid = 1'b0;
  logic        I_rxactive = 1'b0;
  logic        I_rxerror = 1'b0;
  logic [7:0]  O_data;
  logic        O_data_valid, O_sop, O_eop, O_eop_err;
  logic [3:0]  O_pid;
  logic [10:0] O_pkt_len;
  logic [15:0] O_pkt_count, O_drop_count, O_err_count;

  pw_pid_filter #(.pLEN_WIDTH(11), .pCNT_WIDTH(16)) dut (
    .fe_clk(fe_clk), .reset_i(reset_i), .I_enable(I_enable),
    .I_clear_counts(I_clear_counts), .I_drop_mask(I_drop_mask),
    .I_data(I_data), .I_rxvalid(I_rxvalid), .I_rxactive(I_rxactive),
    .I_rxerror(I_rxerror), .O_data(O_data), .O_data_valid(O_data_valid),
    .O_sop(O_sop), .O_eop(O_eop), .O_eop_err(O_eop_err), .O_pid(O_pid),
    .O_pkt_len(O_pkt_len), .O_pkt_count(O_pkt_count),
    .O_drop_count(O_drop_count), .O_err_count(O_err_count)
  );

  always #5 fe_clk = ~fe_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed stream
  logic [7:0] obs_q[$];
  int obs_sop, obs_eop, obs_eop_err;
  // Expected stream and registers
  logic [7:0]  exp_q[$];
  int          exp_sop, exp_eop, exp_eop_err;
  logic [15:0] exp_pkt = '0, exp_drop = '0, exp_err = '0;
  logic [10:0] exp_len = '0;
  logic [3:0]  exp_pid = '0;

  always @(negedge fe_clk) begin
    if (O_data_valid) obs_q.push_back(O_data);
    if (O_sop) obs_sop++;
    if (O_eop) begin
      obs_eop++;
      if (O_eop_err) obs_eop_err++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic clear_obs();
    obs_q.delete(); exp_q.delete();
    obs_sop = 0; obs_eop = 0; obs_eop_err = 0;
    exp_sop = 0; exp_eop = 0; exp_eop_err = 0;
  endtask

  task automatic tick();
    @(posedge fe_clk); #1;
  endtask

  // Packet-level reference: what a packet should produce given its bytes,
  // the byte index carrying rxerror (-1 = none) and the drop mask.
  task automatic model_pkt(input bq_t b, input int err_idx, input logic [15:0] mask);
    logic [7:0] p;
    int last;
    p = b[0];
    if (err_idx == 0 || p[7:4] != ~p[3:0]) begin
      exp_err++;
      return;
    end
    if (mask[p[3:0]]) begin
      exp_drop++;
      return;
    end
    last = (err_idx > 0) ? err_idx : b.size();
    for (int i = 0; i < last; i++) exp_q.push_back(b[i]);
    exp_sop++; exp_eop++;
    exp_pid = p[3:0];
    if (err_idx > 0) begin
      exp_eop_err++; exp_err++;
    end else begin
      exp_pkt++;
      exp_len = 11'(b.size());
    end
  endtask

  // Called aligned to posedge+1 with rxactive low.
  task automatic send_pkt(input bq_t b, input int err_idx, input int gap_max, input int idle);
    I_rxactive = 1'b1; I_rxvalid = 1'b0; I_rxerror = 1'b0;
    tick();
    foreach (b[i]) begin
      repeat ($urandom_range(gap_max, 0)) tick();
      I_data = b[i]; I_rxvalid = 1'b1; I_rxerror = (i == err_idx);
      tick();
      I_rxvalid = 1'b0; I_rxerror = 1'b0;
    end
    I_rxactive = 1'b0;
    repeat (idle) tick();
  endtask

  task automatic pulse_clear();
    I_clear_counts = 1'b1; tick(); I_clear_counts = 1'b0;
    exp_pkt = '0; exp_drop = '0; exp_err = '0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if ({O_data, O_data_valid, O_sop, O_eop, O_eop_err, O_pid, O_pkt_len,
         O_pkt_count, O_drop_count, O_err_count} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero outputs data=%h pkt=%0d, need all 0", O_data, O_pkt_count);
    end
    reset_i = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({O_data_valid, O_eop, O_pkt_count} !== '0) begin
      n_fail++; $display("FAIL idle_after_reset: dv=%b eop=%b pkt=%0d, need 0", O_data_valid, O_eop, O_pkt_count);
    end
  endtask

  task automatic test_in_token();
    logic [7:0] bytes_in[3];
    bytes_in = '{8'h69, 8'h82, 8'h18};
    clear_obs();
    I_rxactive = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      I_data = bytes_in[i]; I_rxvalid = 1'b1; tick();
      n_checks++;
      if (O_data_valid !== 1'b1 || O_data !== bytes_in[i] || O_sop !== (i == 0)) begin
        n_fail++; $display("FAIL in_token_byte%0d: dv=%b data=%h sop=%b, need 1 %h %b", i, O_data_valid, O_data, O_sop, bytes_in[i], i == 0);
      end
    end
    I_rxvalid = 1'b0; I_rxactive = 1'b0; tick();
    n_checks++;
    if (O_eop !== 1'b1 || O_eop_err !== 1'b0 || O_data_valid !== 1'b0) begin
      n_fail++; $display("FAIL in_token_eop: eop=%b err=%b dv=%b, need 1 0 0", O_eop, O_eop_err, O_data_valid);
    end
    n_checks++;
    if (O_pkt_len !== 11'd3 || O_pkt_count !== 16'd1 || O_pid !== 4'h9) begin
      n_fail++; $display("FAIL in_token_regs: len=%0d pkt=%0d pid=%h, need 3 1 9", O_pkt_len, O_pkt_count, O_pid);
    end
    tick();
    exp_pkt = 16'd1; exp_len = 11'd3; exp_pid = 4'h9;
  endtask

  task automatic test_drop();
    clear_obs();
    I_drop_mask = 16'h0020;
    send_pkt('{8'hA5, 8'h3C, 8'h11}, -1, 1, 2);
    model_pkt('{8'hA5, 8'h3C, 8'h11}, -1, 16'h0020);
    I_drop_mask = '0;
    n_checks++;
    if (obs_q.size() != 0 || obs_sop != 0) begin
      n_fail++; $display("FAIL drop_stream: bytes=%0d sop=%0d, need 0 0", obs_q.size(), obs_sop);
    end
    n_checks++;
    if (O_drop_count !== exp_drop || O_pkt_count !== exp_pkt) begin
      n_fail++; $display("FAIL drop_counts: drop=%0d pkt=%0d, need %0d %0d", O_drop_count, O_pkt_count, exp_drop, exp_pkt);
    end
  endtask

  task automatic test_bad_pid();
    clear_obs();
    pulse_clear();
    send_pkt('{8'h55, 8'h01, 8'h02}, -1, 0, 1);
    model_pkt('{8'h55, 8'h01, 8'h02}, -1, 16'h0000);
    send_pkt('{8'hD2}, -1, 0, 2);
    model_pkt('{8'hD2}, -1, 16'h0000);
    n_checks++;
    if (O_err_count !== 16'd1) begin
      n_fail++; $display("FAIL bad_pid_err: err=%0d, need 1", O_err_count);
    end
    n_checks++;
    if (obs_q.size() != 1 || obs_sop != 1 || obs_eop != 1) begin
      n_fail++; $display("FAIL bad_pid_next: bytes=%0d sop=%0d eop=%0d, need 1 1 1", obs_q.size(), obs_sop, obs_eop);
    end else begin
      n_checks++;
      if (obs_q[0] !== 8'hD2 || O_pid !== 4'h2 || O_pkt_len !== 11'd1) begin
        n_fail++; $display("FAIL bad_pid_ack: data=%h pid=%h len=%0d, need d2 2 1", obs_q[0], O_pid, O_pkt_len);
      end
    end
  endtask

  task automatic test_rxerror();
    bq_t b;
    b = '{8'hC3, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    clear_obs();
    pulse_clear();
    send_pkt(b, 3, 0, 2);
    model_pkt(b, 3, 16'h0000);
    n_checks++;
    if (obs_q.size() != 3) begin
      n_fail++; $display("FAIL rxerror_count: bytes=%0d, need 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rxerror_byte%0d: got %h, need %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (obs_eop != 1 || obs_eop_err != 1 || O_err_count !== 16'd1 || O_pkt_count !== 16'd0) begin
      n_fail++; $display("FAIL rxerror_end: eop=%0d eop_err=%0d err=%0d pkt=%0d, need 1 1 1 0", obs_eop, obs_eop_err, O_err_count, O_pkt_count);
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    pulse_clear();
    send_pkt('{8'hD2}, -1, 0, 1);
    model_pkt('{8'hD2}, -1, 16'h0000);
    send_pkt('{8'h5A}, -1, 0, 2);
    model_pkt('{8'h5A}, -1, 16'h0000);
    n_checks++;
    if (obs_sop != 2 || obs_eop != 2 || O_pkt_count !== 16'd2) begin
      n_fail++; $display("FAIL back_to_back: sop=%0d eop=%0d pkt=%0d, need 2 2 2", obs_sop, obs_eop, O_pkt_count);
    end
    n_checks++;
    if (obs_q.size() != 2 || O_pid !== 4'hA) begin
      n_fail++; $display("FAIL back_to_back_data: bytes=%0d pid=%h, need 2 a", obs_q.size(), O_pid);
    end
  endtask

  task automatic test_enable();
    clear_obs();
    I_enable = 1'b0;
    send_pkt('{8'h69, 8'h01, 8'h02}, -1, 0, 2);
    I_enable = 1'b1;
    n_checks++;
    if (obs_q.size() != 0 || O_pkt_count !== exp_pkt || O_err_count !== exp_err) begin
      n_fail++; $display("FAIL disabled: bytes=%0d pkt=%0d err=%0d, need 0 %0d %0d", obs_q.size(), O_pkt_count, O_err_count, exp_pkt, exp_err);
    end
    // Enable drops mid-packet: the packet still completes.
    I_rxactive = 1'b1; tick();
    I_data = 8'hC3; I_rxvalid = 1'b1; tick();
    I_enable = 1'b0; I_data = 8'h11; tick();
    I_rxvalid = 1'b0; I_rxactive = 1'b0; tick(); tick();
    I_enable = 1'b1;
    model_pkt('{8'hC3, 8'h11}, -1, 16'h0000);
    n_checks++;
    if (obs_q.size() != 2 || obs_eop != 1 || O_pkt_count !== exp_pkt || O_pkt_len !== 11'd2) begin
      n_fail++; $display("FAIL enable_midpkt: bytes=%0d eop=%0d pkt=%0d len=%0d, need 2 1 %0d 2", obs_q.size(), obs_eop, O_pkt_count, exp_pkt, O_pkt_len);
    end
  endtask

  task automatic test_async_reset();
    clear_obs();
    I_rxactive = 1'b1; tick();
    I_data = 8'h4B; I_rxvalid = 1'b1; tick();
    I_data = 8'h77; tick();
    n_checks++;
    if (O_data_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_fwd: dv=%b, need 1", O_data_valid);
    end
    #2 reset_i = 1'b1;
    #1;
    n_checks++;
    if ({O_data, O_data_valid, O_sop, O_eop, O_eop_err, O_pid, O_pkt_len,
         O_pkt_count, O_drop_count, O_err_count} !== '0) begin
      n_fail++; $display("FAIL async_reset: dv=%b data=%h pkt=%0d err=%0d, need all 0", O_data_valid, O_data, O_pkt_count, O_err_count);
    end
    I_rxvalid = 1'b0; I_rxactive = 1'b0;
    tick(); reset_i = 1'b0; tick();
    exp_pkt = '0; exp_drop = '0; exp_err = '0; exp_len = '0; exp_pid = '0;
    clear_obs();
    send_pkt('{8'h4B, 8'h01, 8'h02, 8'h03}, -1, 1, 2);
    model_pkt('{8'h4B, 8'h01, 8'h02, 8'h03}, -1, 16'h0000);
    n_checks++;
    if (obs_q.size() != 4 || O_pkt_count !== 16'd1 || O_pkt_len !== 11'd4 || O_pid !== 4'hB) begin
      n_fail++; $display("FAIL after_reset_pkt: bytes=%0d pkt=%0d len=%0d pid=%h, need 4 1 4 b", obs_q.size(), O_pkt_count, O_pkt_len, O_pid);
    end
  endtask

  task automatic test_clear_counts();
    clear_obs();
    I_rxactive = 1'b1; tick();
    I_data = 8'hD2; I_rxvalid = 1'b1; tick();
    I_rxvalid = 1'b0; I_rxactive = 1'b0; I_clear_counts = 1'b1; tick();
    I_clear_counts = 1'b0;
    n_checks++;
    if (O_eop !== 1'b1 || O_pkt_len !== 11'd1) begin
      n_fail++; $display("FAIL clear_eop: eop=%b len=%0d, need 1 1", O_eop, O_pkt_len);
    end
    n_checks++;
    if (O_pkt_count !== 16'd0 || O_drop_count !== 16'd0 || O_err_count !== 16'd0) begin
      n_fail++; $display("FAIL clear_priority: pkt=%0d drop=%0d err=%0d, need 0 0 0", O_pkt_count, O_drop_count, O_err_count);
    end
    tick();
    exp_pkt = '0; exp_drop = '0; exp_err = '0; exp_len = 11'd1; exp_pid = 4'h2;
  endtask

  task automatic test_random();
    bq_t b;
    int len, err_idx;
    logic [3:0] n;
    logic [7:0] p;
    logic [15:0] mask;
    clear_obs();
    for (int k = 0; k < 60; k++) begin
      len = $urandom_range(8, 1);
      n = 4'($urandom_range(15, 0));
      p = {~n, n};
      if ($urandom_range(5, 0) == 0) p = p ^ 8'h10;
      b.delete();
      b.push_back(p);
      for (int i = 1; i < len; i++) b.push_back(8'($urandom));
      err_idx = ($urandom_range(4, 0) == 0) ? $urandom_range(len - 1, 0) : -1;
      mask = 16'($urandom & $urandom);
      I_drop_mask = mask;
      send_pkt(b, err_idx, 2, $urandom_range(3, 1));
      model_pkt(b, err_idx, mask);
    end
    tick();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL random_len: bytes=%0d, need %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL random_byte%0d: got %h, need %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (obs_sop != exp_sop || obs_eop != exp_eop || obs_eop_err != exp_eop_err) begin
      n_fail++; $display("FAIL random_markers: sop=%0d eop=%0d eop_err=%0d, need %0d %0d %0d", obs_sop, obs_eop, obs_eop_err, exp_sop, exp_eop, exp_eop_err);
    end
    n_checks++;
    if (O_pkt_count !== exp_pkt || O_drop_count !== exp_drop || O_err_count !== exp_err) begin
      n_fail++; $display("FAIL random_counts: pkt=%0d drop=%0d err=%0d, need %0d %0d %0d", O_pkt_count, O_drop_count, O_err_count, exp_pkt, exp_drop, exp_err);
    end
    n_checks++;
    if (O_pkt_len !== exp_len || O_pid !== exp_pid) begin
      n_fail++; $display("FAIL random_last: len=%0d pid=%h, need %0d %h", O_pkt_len, O_pid, exp_len, exp_pid);
    end
  endtask

  initial begin
    test_reset();
    test_in_token();
    test_drop();
    test_bad_pid();
    test_rxerror();
    test_back_to_back();
    test_enable();
    test_async_reset();
    test_clear_counts();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
